// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// the FSM state type, the latency counter width and access-decode helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Loads accept all five encodings; stores only the three signed ones.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

  // Natural-alignment rule for the access size selected by funct3.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at byte offset a.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << a;
      F3_H, F3_HU: return a[1] ? 4'b1100 : 4'b0011;
      F3_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory
// responder. The requester owns req_* (except req_ready); the responder
// owns req_ready, resp_* and busy.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_store_array.sv
// Word-organised storage with per-byte write enables and a registered read.
// Read data appears on the edge after the address is presented.
module dmem_store_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // Byte-masked write and registered read on the same address.
  // NOTE: the array has no reset so it maps onto RAM macros; contents survive rst.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder. Accepts one load/store at a time,
// waits LATENCY cycles (counting the RESP cycle), commits on the edge that
// enters RESP and pulses resp_valid for one cycle.
//
// Timing relative to the accept edge E0: the commit edge is E0+LATENCY-1,
// so resp_valid is high in the LATENCY-th cycle after acceptance and a new
// request can be accepted every LATENCY+1 cycles. The array read is issued
// one edge before the commit edge; for LATENCY=1 that is the edge before
// acceptance, so the requester must present req_addr at least one cycle
// before the accepting edge (holding the request stable does this).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               accept;
  logic               commit;

  logic               lat_write;
  logic [31:0]        lat_addr;
  logic [31:0]        lat_wdata;
  logic [2:0]         lat_f3;

  logic               cur_write;
  logic [31:0]        cur_addr;
  logic [31:0]        cur_wdata;
  logic [2:0]         cur_f3;

  logic               out_of_range;
  logic               err;
  logic               store_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [3:0]         arr_be;
  logic [31:0]        arr_wdata;
  logic [31:0]        arr_rdata;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ext;

  logic [31:0]        resp_rdata_q;
  logic               resp_err_q;

  // The access being committed: straight from the bus when committing out of
  // IDLE (LATENCY=1), otherwise from the fields captured at acceptance.
  assign cur_write = (state == IDLE) ? bus.req_write  : lat_write;
  assign cur_addr  = (state == IDLE) ? bus.req_addr   : lat_addr;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata  : lat_wdata;
  assign cur_f3    = (state == IDLE) ? bus.req_funct3 : lat_f3;

  // Only WAIT needs the captured address; elsewhere the array tracks the bus
  // so a read started the edge before acceptance is already in flight.
  assign arr_addr = (state == WAIT) ? lat_addr[ADDR_WIDTH+1:2]
                                    : bus.req_addr[ADDR_WIDTH+1:2];

  assign out_of_range = (cur_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign err = !f3_legal(cur_write, cur_f3) || misaligned(cur_f3, cur_addr[1:0])
               || out_of_range;

  // A reset landing on the commit edge cancels the store.
  assign store_we = commit && !rst && cur_write && !err;
  assign arr_be   = store_we ? lane_mask(cur_f3, cur_addr[1:0]) : 4'b0000;

  // Narrow stores replicate their data; the byte enables pick the lanes.
  always_comb begin
    case (cur_f3)
      F3_B:    arr_wdata = {4{cur_wdata[7:0]}};
      F3_H:    arr_wdata = {2{cur_wdata[15:0]}};
      default: arr_wdata = cur_wdata;
    endcase
  end

  dmem_store_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .addr  (arr_addr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Select the addressed byte and halfword out of the read word.
  always_comb begin
    case (cur_addr[1:0])
      2'd0:    ld_byte = arr_rdata[7:0];
      2'd1:    ld_byte = arr_rdata[15:8];
      2'd2:    ld_byte = arr_rdata[23:16];
      default: ld_byte = arr_rdata[31:24];
    endcase
    ld_half = cur_addr[1] ? arr_rdata[31:16] : arr_rdata[15:0];
  end

  // Sign- or zero-extend the selected lane data.
  always_comb begin
    case (cur_f3)
      F3_B:    ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ext = {24'd0, ld_byte};
      F3_H:    ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ext = {16'd0, ld_half};
      F3_W:    ext = arr_rdata;
      default: ext = 32'd0;
    endcase
  end

  // Next-state, counter and commit decode.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and latency counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the request at acceptance; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
      lat_f3    <= bus.req_funct3;
    end
  end

  // Response registers: loaded on the commit edge, cleared after RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else if (commit) begin
      resp_rdata_q <= (err || cur_write) ? 32'd0 : ext;
      resp_err_q   <= err;
    end else if (state == RESP) begin
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end
  end

  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
